// File: rtl/mem_arb_pkg.sv
// ============================================================================
// Module   : mem_arb_pkg
// Purpose  : Shared types and helpers for the unified main-memory arbiter.
//            Holds the arbiter state encoding, the requester-owner encoding,
//            the big-endian byte-lane array used on the memory data buses,
//            and the word <-> lane pack/unpack helpers.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned CNT_W  = 4;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_ACCESS  = 2'd1,
    ARB_RESPOND = 2'd2
  } arb_state_t;

  // Current / last grant holder
  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } arb_owner_t;

  // Four byte lanes, lane 0 is the most significant byte of the word
  typedef logic [0:3][7:0] byte_lanes_t;

  // Split a word into big-endian byte lanes
  function automatic byte_lanes_t word_to_lanes(input logic [WORD_W-1:0] w);
    byte_lanes_t l;
    l[0] = w[31:24];
    l[1] = w[23:16];
    l[2] = w[15:8];
    l[3] = w[7:0];
    return l;
  endfunction

  // Reassemble a word from big-endian byte lanes
  function automatic logic [WORD_W-1:0] lanes_to_word(input byte_lanes_t l);
    return {l[0], l[1], l[2], l[3]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/starve_counter.sv
// ============================================================================
// Module   : starve_counter
// Purpose  : Saturating 4-bit counter used to track how many consecutive
//            cycles the instruction-fetch side has been kept waiting.
//            Clear has priority over increment; the count never exceeds
//            STARVE_LIMIT.
// Ports    : clk        - clock, rising edge
//            rst_b      - asynchronous active-low reset
//            i_inc      - count one more waiting cycle
//            i_clr      - return the count to zero
//            o_at_limit - count equals STARVE_LIMIT
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module starve_counter
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst_b,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_at_limit
);

  localparam logic [CNT_W-1:0] c_LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count < c_LIMIT)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_at_limit = (r_count == c_LIMIT);

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares the single unified main-memory port between the
//            instruction-fetch side (I) and the data-cache side (D).
//            Whole transactions are serialised: a request is sampled in
//            IDLE, held in ACCESS for MEM_LATENCY cycles, and answered with
//            a one-cycle ready pulse in RESPOND. D has fixed priority; a
//            starvation counter forces an I grant once I has waited
//            STARVE_LIMIT cycles.
// Ports    : clk, rst_b          - clock / async active-low reset
//            i_req, i_addr       - instruction read request and address
//            i_ready, i_rdata    - instruction ready pulse and read word
//            d_req, d_we         - data request, 1 = write
//            d_addr, d_wdata     - data address and write word
//            d_ready, d_rdata    - data ready pulse and read word
//            mem_addr            - memory address (latched per transaction)
//            mem_data_in         - write lanes to memory (big-endian)
//            mem_write_en        - write strobe, first ACCESS cycle only
//            mem_data_out        - read lanes from memory (big-endian)
//            busy                - high in ACCESS and RESPOND
//            owner               - current or last grant (0 = I, 1 = D)
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_LATENCY  = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_b,
  // instruction-fetch side
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ready,
  output logic [31:0] i_rdata,
  // data-cache side
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  // memory port
  output logic [31:0] mem_addr,
  output byte_lanes_t mem_data_in,
  output logic        mem_write_en,
  input  byte_lanes_t mem_data_out,
  // status
  output logic        busy,
  output arb_owner_t  owner
);

  // ACCESS lasts MEM_LATENCY cycles, so the down-counter starts one short
  localparam logic [CNT_W-1:0] c_CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

  arb_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  arb_owner_t       r_owner;
  logic             r_we;
  logic [31:0]      r_mem_addr;
  byte_lanes_t      r_mem_data_in;
  logic             r_mem_we;
  logic [31:0]      r_i_rdata;
  logic [31:0]      r_d_rdata;
  logic             r_i_ready;
  logic             r_d_ready;
  logic             r_busy;

  logic w_idle;
  logic w_at_limit;
  logic w_grant_d;
  logic w_grant_i;
  logic w_i_owns;
  logic w_starve_inc;
  logic w_starve_clr;

  assign w_idle = (r_state == ARB_IDLE);

  // D wins a contested IDLE edge unless I has waited out the limit
  assign w_grant_d = w_idle && d_req && !(i_req && w_at_limit);
  assign w_grant_i = w_idle && i_req && !w_grant_d;

  // I is being served while a transaction it owns is in flight
  assign w_i_owns     = !w_idle && (r_owner == OWNER_I);
  assign w_starve_inc = i_req && !w_i_owns;
  assign w_starve_clr = !i_req || w_grant_i;

  starve_counter #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk        (clk),
    .rst_b      (rst_b),
    .i_inc      (w_starve_inc),
    .i_clr      (w_starve_clr),
    .o_at_limit (w_at_limit)
  );

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state       <= ARB_IDLE;
      r_cnt         <= '0;
      r_owner       <= OWNER_I;
      r_we          <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_data_in <= '0;
      r_mem_we      <= 1'b0;
      r_i_rdata     <= '0;
      r_d_rdata     <= '0;
      r_i_ready     <= 1'b0;
      r_d_ready     <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      // Pulses default low; each is raised for exactly one cycle below
      r_i_ready <= 1'b0;
      r_d_ready <= 1'b0;
      r_mem_we  <= 1'b0;

      case (r_state)
        ARB_IDLE: begin
          if (w_grant_d || w_grant_i) begin
            r_state       <= ARB_ACCESS;
            r_busy        <= 1'b1;
            r_cnt         <= c_CNT_LOAD;
            r_owner       <= w_grant_d ? OWNER_D : OWNER_I;
            r_mem_addr    <= w_grant_d ? d_addr : i_addr;
            // Instruction fetches are always reads
            r_we          <= w_grant_d && d_we;
            r_mem_we      <= w_grant_d && d_we;
            r_mem_data_in <= word_to_lanes(d_wdata);
          end
        end

        ARB_ACCESS: begin
          if (r_cnt == '0) begin
            r_state <= ARB_RESPOND;
            if (r_owner == OWNER_D) begin
              r_d_ready <= 1'b1;
              // Writes leave the previous read data in place
              if (!r_we) begin
                r_d_rdata <= lanes_to_word(mem_data_out);
              end
            end else begin
              r_i_ready <= 1'b1;
              r_i_rdata <= lanes_to_word(mem_data_out);
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        ARB_RESPOND: begin
          r_state <= ARB_IDLE;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state <= ARB_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign i_ready      = r_i_ready;
  assign i_rdata      = r_i_rdata;
  assign d_ready      = r_d_ready;
  assign d_rdata      = r_d_rdata;
  assign mem_addr     = r_mem_addr;
  assign mem_data_in  = r_mem_data_in;
  assign mem_write_en = r_mem_we;
  assign busy         = r_busy;
  assign owner        = r_owner;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Self-checking bench for mem_arbiter. A transaction-level
//            reference model (elapsed cycles since grant) predicts every
//            output; directed scenarios check the documented behaviours
//            against constants.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int ML  = 2;
  localparam int SL  = 4;
  localparam int ML1 = 1;

  logic        clk;
  logic        rst_b;

  // main instance (MEM_LATENCY = 2)
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic        i_ready, d_ready, mem_write_en, busy, owner;
  logic [31:0] i_rdata, d_rdata, mem_addr;
  byte_lanes_t mem_data_in, mem_data_out;

  // second instance (MEM_LATENCY = 1)
  logic        d_req1;
  logic [31:0] d_addr1;
  logic        i_ready1, d_ready1, mem_write_en1, busy1, owner1;
  logic [31:0] i_rdata1, d_rdata1, mem_addr1;
  byte_lanes_t mem_data_in1, mem_data_out1;

  int checks;
  int failures;

  // memory model
  logic        use_ovr;
  logic [31:0] ovr;

  mem_arbiter #(.MEM_LATENCY(ML), .STARVE_LIMIT(SL)) u_dut (
    .clk(clk), .rst_b(rst_b),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_write_en(mem_write_en),
    .mem_data_out(mem_data_out), .busy(busy), .owner(owner)
  );

  mem_arbiter #(.MEM_LATENCY(ML1), .STARVE_LIMIT(SL)) u_dut1 (
    .clk(clk), .rst_b(rst_b),
    .i_req(1'b0), .i_addr(32'h0), .i_ready(i_ready1), .i_rdata(i_rdata1),
    .d_req(d_req1), .d_we(1'b0), .d_addr(d_addr1), .d_wdata(32'h0),
    .d_ready(d_ready1), .d_rdata(d_rdata1),
    .mem_addr(mem_addr1), .mem_data_in(mem_data_in1), .mem_write_en(mem_write_en1),
    .mem_data_out(mem_data_out1), .busy(busy1), .owner(owner1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] hash(input logic [31:0] a);
    return {a[7:0] ^ 8'h5A, a[15:8] + 8'h11, ~a[7:0], a[23:16] ^ 8'hC3};
  endfunction

  function automatic logic [31:0] lanes_word(input byte_lanes_t l);
    return {l[0], l[1], l[2], l[3]};
  endfunction

  logic [31:0] w_mem0, w_mem1;
  always_comb begin
    w_mem0 = use_ovr ? ovr : hash(mem_addr);
    mem_data_out[0] = w_mem0[31:24];
    mem_data_out[1] = w_mem0[23:16];
    mem_data_out[2] = w_mem0[15:8];
    mem_data_out[3] = w_mem0[7:0];
    w_mem1 = hash(mem_addr1);
    mem_data_out1[0] = w_mem1[31:24];
    mem_data_out1[1] = w_mem1[23:16];
    mem_data_out1[2] = w_mem1[15:8];
    mem_data_out1[3] = w_mem1[7:0];
  end

  // ---------------- reference model (main instance) ----------------
  // m_phase = cycles since grant (0 = idle); ready at ML+1.
  int          m_phase;
  bit          m_own;
  logic [31:0] m_addr, m_wdata, m_irdata, m_drdata;
  bit          m_we;
  int          m_iwait;

  task automatic model_reset();
    m_phase = 0; m_own = 0; m_addr = 0; m_wdata = 0; m_we = 0;
    m_irdata = 0; m_drdata = 0; m_iwait = 0;
  endtask

  // Advance the model using the inputs present before the edge, then the clock
  task automatic tick();
    bit gi, gd, i_owned;
    logic [31:0] mval;
    gi = 0; gd = 0;
    i_owned = (m_phase != 0) && (m_own == 1'b0);
    if (m_phase == 0) begin
      if (d_req && !(i_req && m_iwait == SL)) gd = 1;
      else if (i_req) gi = 1;
    end
    if (!i_req || gi) m_iwait = 0;
    else if (!i_owned && m_iwait < SL) m_iwait++;
    if (gi || gd) begin
      m_phase = 1; m_own = gd;
      m_addr = gd ? d_addr : i_addr;
      m_we = gd && d_we;
      m_wdata = d_wdata;
    end else if (m_phase == ML + 1) begin
      m_phase = 0;
    end else if (m_phase != 0) begin
      m_phase++;
      if (m_phase == ML + 1 && !m_we) begin
        mval = use_ovr ? ovr : hash(m_addr);
        if (m_own) m_drdata = mval; else m_irdata = mval;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int n = 0; n < 20 && m_phase != 0; n++) tick();
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL drain_busy got=%b want=0", busy);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    checks++; if (busy !== 1'b0 || i_ready !== 1'b0 || d_ready !== 1'b0 || mem_write_en !== 1'b0) begin
      failures++; $display("FAIL reset_ctrl busy=%b ir=%b dr=%b we=%b want=0", busy, i_ready, d_ready, mem_write_en);
    end
    checks++; if (mem_addr !== 32'h0 || lanes_word(mem_data_in) !== 32'h0) begin
      failures++; $display("FAIL reset_mem addr=%h din=%h want=0", mem_addr, lanes_word(mem_data_in));
    end
    checks++; if (i_rdata !== 32'h0 || d_rdata !== 32'h0 || owner !== 1'b0) begin
      failures++; $display("FAIL reset_data ird=%h drd=%h own=%b want=0", i_rdata, d_rdata, owner);
    end
  endtask

  task automatic test_d_read();
    int first, pulses, we_seen;
    first = -1; pulses = 0; we_seen = 0;
    use_ovr = 1; ovr = 32'hDEADBEEF;
    d_addr = 32'h40; d_we = 1'b0; d_wdata = $urandom; d_req = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      tick();
      if (mem_write_en) we_seen++;
      if (d_ready) begin
        pulses++;
        if (first < 0) first = n;
        d_req = 1'b0;
        checks++; if (d_rdata !== 32'hDEADBEEF) begin
          failures++; $display("FAIL dread_data got=%h want=deadbeef", d_rdata);
        end
      end
    end
    checks++; if (first != ML + 1) begin failures++; $display("FAIL dread_latency got=%0d want=%0d", first, ML + 1); end
    checks++; if (pulses != 1) begin failures++; $display("FAIL dread_pulses got=%0d want=1", pulses); end
    checks++; if (we_seen != 0) begin failures++; $display("FAIL dread_we got=%0d want=0", we_seen); end
    drain();
  endtask

  task automatic test_d_write();
    int we_cnt, pulses;
    logic [31:0] lanes_at_we, addr_at_we;
    we_cnt = 0; pulses = 0; lanes_at_we = 0; addr_at_we = 0;
    ovr = 32'h0BAD0BAD;
    d_addr = 32'h80; d_we = 1'b1; d_wdata = 32'h12345678; d_req = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      tick();
      if (mem_write_en) begin
        we_cnt++;
        lanes_at_we = {mem_data_in[0], mem_data_in[1], mem_data_in[2], mem_data_in[3]};
        addr_at_we = mem_addr;
      end
      if (d_ready) begin pulses++; d_req = 1'b0; end
    end
    checks++; if (we_cnt != 1) begin failures++; $display("FAIL dwrite_we_cycles got=%0d want=1", we_cnt); end
    checks++; if (lanes_at_we !== 32'h12345678) begin failures++; $display("FAIL dwrite_lanes got=%h want=12345678", lanes_at_we); end
    checks++; if (addr_at_we !== 32'h80) begin failures++; $display("FAIL dwrite_addr got=%h want=00000080", addr_at_we); end
    checks++; if (pulses != 1) begin failures++; $display("FAIL dwrite_ready got=%0d want=1", pulses); end
    checks++; if (d_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL dwrite_rdata got=%h want=deadbeef", d_rdata); end
    drain();
  endtask

  task automatic test_i_only();
    int first, dpulses, bad_owner;
    first = -1; dpulses = 0; bad_owner = 0;
    ovr = 32'h8C010004;
    d_we = 1'b0;
    i_addr = 32'h100; i_req = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      tick();
      if (owner !== 1'b0) bad_owner++;
      if (d_ready) dpulses++;
      if (i_ready) begin
        if (first < 0) first = n;
        i_req = 1'b0;
        checks++; if (i_rdata !== 32'h8C010004) begin
          failures++; $display("FAIL ionly_data got=%h want=8c010004", i_rdata);
        end
      end
    end
    checks++; if (first != ML + 1) begin failures++; $display("FAIL ionly_latency got=%0d want=%0d", first, ML + 1); end
    checks++; if (bad_owner != 0) begin failures++; $display("FAIL ionly_owner bad_cycles=%0d want=0", bad_owner); end
    checks++; if (dpulses != 0) begin failures++; $display("FAIL ionly_dready got=%0d want=0", dpulses); end
    drain();
  endtask

  task automatic test_starve();
    bit seq[$];
    logic [31:0] i_grant_addr;
    use_ovr = 0; i_grant_addr = 32'h0;
    i_addr = 32'h200; d_addr = 32'h300; d_we = 1'b0;
    i_req = 1'b1; d_req = 1'b1;
    for (int n = 1; n <= 3 * (ML + 2); n++) begin
      tick();
      if (d_ready) seq.push_back(1'b1);
      if (i_ready) begin seq.push_back(1'b0); i_grant_addr = mem_addr; end
    end
    i_req = 1'b0; d_req = 1'b0;
    checks++;
    if (seq.size() != 3) begin
      failures++; $display("FAIL starve_count got=%0d want=3", seq.size());
    end else if (seq[0] != 1'b1 || seq[1] != 1'b0 || seq[2] != 1'b1) begin
      failures++; $display("FAIL starve_order got=%b%b%b want=101", seq[0], seq[1], seq[2]);
    end
    checks++; if (i_grant_addr !== 32'h200) begin failures++; $display("FAIL starve_iaddr got=%h want=00000200", i_grant_addr); end
    checks++; if (d_rdata !== hash(32'h300) || i_rdata !== hash(32'h200)) begin
      failures++; $display("FAIL starve_data d=%h i=%h want d=%h i=%h", d_rdata, i_rdata, hash(32'h300), hash(32'h200));
    end
    drain();
  endtask

  task automatic test_reset_mid();
    int pulses, first, we_first;
    pulses = 0; first = -1;
    d_addr = 32'h84; d_we = 1'b1; d_wdata = $urandom; d_req = 1'b1;
    tick();
    we_first = mem_write_en;
    tick();
    checks++; if (we_first != 1 || busy !== 1'b1) begin
      failures++; $display("FAIL rstmid_pre we=%0d busy=%b want 1 1", we_first, busy);
    end
    rst_b = 1'b0;
    #1;
    model_reset();
    checks++; if (busy !== 1'b0 || d_ready !== 1'b0 || mem_write_en !== 1'b0 || owner !== 1'b0) begin
      failures++; $display("FAIL rstmid_ctrl busy=%b dr=%b we=%b own=%b want=0", busy, d_ready, mem_write_en, owner);
    end
    checks++; if (mem_addr !== 32'h0 || lanes_word(mem_data_in) !== 32'h0 || d_rdata !== 32'h0 || i_rdata !== 32'h0) begin
      failures++; $display("FAIL rstmid_data addr=%h din=%h drd=%h ird=%h want=0", mem_addr, lanes_word(mem_data_in), d_rdata, i_rdata);
    end
    d_req = 1'b0;
    tick();
    rst_b = 1'b1;
    for (int n = 0; n < 5; n++) begin
      tick();
      if (d_ready) pulses++;
    end
    checks++; if (pulses != 0) begin failures++; $display("FAIL rstmid_noready got=%0d want=0", pulses); end
    use_ovr = 1; ovr = 32'hCAFEF00D;
    d_addr = 32'h40; d_we = 1'b0; d_req = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      tick();
      if (d_ready && first < 0) begin first = n; d_req = 1'b0; end
    end
    checks++; if (first != ML + 1 || d_rdata !== 32'hCAFEF00D) begin
      failures++; $display("FAIL rstmid_fresh lat=%0d data=%h want %0d cafef00d", first, d_rdata, ML + 1);
    end
    use_ovr = 0;
    drain();
  endtask

  task automatic test_back_to_back();
    int t[$];
    d_addr1 = 32'h44; d_req1 = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      tick();
      if (d_ready1) begin
        t.push_back(n);
        checks++; if (d_rdata1 !== hash(32'h44)) begin
          failures++; $display("FAIL b2b_data got=%h want=%h", d_rdata1, hash(32'h44));
        end
        if (t.size() == 3) d_req1 = 1'b0;
      end
    end
    checks++;
    if (t.size() != 3) begin
      failures++; $display("FAIL b2b_count got=%0d want=3", t.size());
    end else if (t[0] != ML1 + 1 || t[1] - t[0] != 3 || t[2] - t[1] != 3) begin
      failures++; $display("FAIL b2b_spacing got=%0d,%0d,%0d want=2,5,8", t[0], t[1], t[2]);
    end
  endtask

  task automatic test_random();
    bit e_ir, e_dr, e_busy, e_we;
    use_ovr = 0;
    for (int c = 0; c < 400; c++) begin
      tick();
      e_busy = (m_phase != 0);
      e_ir   = (m_phase == ML + 1) && !m_own;
      e_dr   = (m_phase == ML + 1) && m_own;
      e_we   = (m_phase == 1) && m_we;
      checks++; if (i_ready !== e_ir || d_ready !== e_dr) begin
        failures++; $display("FAIL rand_ready c=%0d got i=%b d=%b want i=%b d=%b", c, i_ready, d_ready, e_ir, e_dr);
      end
      checks++; if (busy !== e_busy || mem_write_en !== e_we || owner !== m_own) begin
        failures++; $display("FAIL rand_ctrl c=%0d got busy=%b we=%b own=%b want %b %b %b", c, busy, mem_write_en, owner, e_busy, e_we, m_own);
      end
      checks++; if (mem_addr !== m_addr || lanes_word(mem_data_in) !== m_wdata) begin
        failures++; $display("FAIL rand_mem c=%0d got addr=%h din=%h want %h %h", c, mem_addr, lanes_word(mem_data_in), m_addr, m_wdata);
      end
      checks++; if (i_rdata !== m_irdata || d_rdata !== m_drdata) begin
        failures++; $display("FAIL rand_rdata c=%0d got i=%h d=%h want %h %h", c, i_rdata, d_rdata, m_irdata, m_drdata);
      end
      // requesters: drop after ready (usually), otherwise occasionally raise
      if (e_ir) i_req = ($urandom_range(3) == 0);
      else if (!i_req) i_req = ($urandom_range(2) == 0);
      if (e_dr) d_req = ($urandom_range(3) == 0);
      else if (!d_req) d_req = ($urandom_range(2) == 0);
      i_addr  = $urandom;
      d_addr  = $urandom;
      d_wdata = $urandom;
      d_we    = $urandom_range(1);
    end
    i_req = 1'b0; d_req = 1'b0;
    drain();
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_b = 1'b0;
    i_req = 0; d_req = 0; d_we = 0; i_addr = 0; d_addr = 0; d_wdata = 0;
    d_req1 = 0; d_addr1 = 0;
    use_ovr = 0; ovr = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_b = 1'b1;
    tick();
    test_reset();
    test_d_read();
    test_d_write();
    test_i_only();
    test_starve();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the single unified main-memory port between the instruction-fetch side and the data-cache side of the pipelined MIPS core. It serialises whole memory transactions, holds each for the fixed memory latency, and returns read data with a one-cycle ready pulse. Data side has fixed priority; a starvation counter guarantees instruction-fetch progress. It sits between `mips_core`/`Cache` and the memory model.

## Interface
Parameters:
- MEM_LATENCY, 2: memory cycles per access; legal range 1..15.
- STARVE_LIMIT, 4: consecutive lost-arbitration cycles after which I-side wins; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst_b  in  1  reset, asynchronous, active-low.
- i_req  in  1  instruction read request; held until i_ready.
- i_addr  in  32  instruction word address.
- i_ready  out  1  one-cycle pulse: i_rdata valid.
- i_rdata  out  32  instruction word.
- d_req  in  1  data request; held until d_ready.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  32  data address.
- d_wdata  in  32  write data.
- d_ready  out  1  one-cycle pulse: transaction done; d_rdata valid on reads.
- d_rdata  out  32  read data.
- mem_addr  out  32  memory address.
- mem_data_in  out  8 x [0:3]  write data lanes to memory.
- mem_write_en  out  1  memory write strobe.
- mem_data_out  in  8 x [0:3]  read data lanes from memory.
- busy  out  1  high in ACCESS and RESPOND.
- owner  out  1  0 = I-side, 1 = D-side; current or last grant.

## Operation
- Lane order is big-endian: lane 0 = bits 31:24, lane 3 = bits 7:0, for both directions.
- States:
  - IDLE: requests are sampled only here.
  - ACCESS: counter cnt runs.
  - RESPOND: one cycle, ready pulse.
- Arbitration at an IDLE edge:
  - Only one requester active: it wins.
  - Both active: D wins unless i_wait == STARVE_LIMIT, in which case I wins.
  - On a grant: latch owner, addr, we (forced 0 for I), and wdata; load cnt = MEM_LATENCY-1; go to ACCESS.
- ACCESS:
  - mem_addr holds the latched address for the whole state.
  - mem_write_en is high only in the first ACCESS cycle, and only for D writes.
  - mem_data_in holds the latched wdata.
  - At an edge with cnt == 0: capture mem_data_out into the owner's rdata register, go to RESPOND. Otherwise decrement cnt.
- RESPOND: owner's ready = 1, then IDLE unconditionally. The other side's rdata is unchanged.
- Requester must drop req in the cycle after its ready pulse. A req still high in IDLE is a new transaction.
- Starvation counter i_wait (4 bits):
  - Increments, saturating at STARVE_LIMIT, on every edge where i_req = 1 and I is not the owner in ACCESS/RESPOND.
  - Clears on I grant, or on any edge with i_req = 0.
- A write returns d_ready; d_rdata is left unchanged.
- Requests that arrive or change during ACCESS/RESPOND are ignored until IDLE. The latched values are used.

## Timing
- Reset values (async on rst_b low):
  - State IDLE; cnt = 0, i_wait = 0, owner = 0.
  - Zero: mem_addr, mem_data_in, i_rdata, d_rdata.
  - Low: mem_write_en, i_ready, d_ready, busy.
- Reset mid-transaction aborts it with no ready pulse. A write strobe in progress drops immediately.
- Grant at edge E0 gives:
  - ACCESS for MEM_LATENCY cycles.
  - ready high in the cycle after edge E0+MEM_LATENCY.
  - IDLE again after E0+MEM_LATENCY+1.
- Throughput: one transaction per MEM_LATENCY+2 cycles. Request-to-ready latency from the IDLE sample is MEM_LATENCY+1 cycles.
- All outputs are registered or decoded from state only. There is no combinational path from requests to outputs.

## Structure
- Package `mem_arb_pkg` holds:
  - `arb_state_t` (ARB_IDLE, ARB_ACCESS, ARB_RESPOND).
  - `arb_owner_t` (OWNER_I = 0, OWNER_D = 1).
  - `byte_lanes_t` (8-bit x 4 lane array).
  - Word/lane pack and unpack functions.
- Sub-module `starve_counter`: saturating 4-bit counter with inc/clr inputs and `at_limit` output, parameterised by STARVE_LIMIT.
- Arbiter FSM and datapath latches live in `mem_arbiter`.

## Test plan
- D read only (MEM_LATENCY = 2), d_addr = 0x40, memory returns lanes {DE,AD,BE,EF}:
  - d_ready pulses exactly 3 cycles after the sample edge.
  - d_rdata = 0xDEADBEEF.
  - mem_write_en stays 0.
- D write d_addr = 0x80, d_wdata = 0x12345678:
  - mem_write_en is high exactly one cycle with lanes {12,34,56,78} and mem_addr = 0x80.
  - d_ready pulses; d_rdata is unchanged.
- Both requesting continuously (STARVE_LIMIT = 4):
  - D wins the first grants.
  - I is granted once i_wait reaches 4.
  - i_wait clears, and D wins the next arbitration.
- i_req only, i_addr = 0x100, memory data 0x8C010004:
  - i_ready pulses with i_rdata = 0x8C010004.
  - owner = 0 throughout.
  - d_ready never pulses.
- rst_b pulled low in the second ACCESS cycle of a D write:
  - All outputs return to reset values immediately.
  - No d_ready.
  - After release, a fresh d_req completes normally.
- MEM_LATENCY = 1 back-to-back D reads with req held through ready: second grant occurs on the first IDLE edge, giving ready pulses 3 cycles apart.
